// File: rtl/matmul_pkg.sv
// Types and helpers shared by the matmul datapath blocks (feed side and drain side).
package matmul_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int unsigned C_M      = 64;
    localparam int unsigned C_N      = 64;
    localparam int unsigned C_ADDR_W = $clog2(C_M * C_N);

    // q sits above sat, so a size cast to OUT_W+1 bits yields {q[OUT_W-1:0], sat}.
    typedef struct packed {
        logic signed [63:0] q;
        logic               sat;
    } quant_t;

    // Rounding arithmetic right shift followed by signed clamp to out_w bits.
    // Inputs narrower than 64 bits are sign-extended by the caller, so the rounding
    // add cannot overflow for accumulators up to 63 bits.
    function automatic quant_t quantize(input logic signed [63:0] acc,
                                        input int unsigned        shift,
                                        input int unsigned        out_w);
        logic signed [63:0] t;
        logic signed [63:0] q;
        logic signed [63:0] q_max;
        logic signed [63:0] q_min;
        quant_t             r;
        t     = acc + ((shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0);
        q     = t >>> shift;
        q_max = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        q_min = -(64'sd1 <<< (out_w - 1));
        r.sat = 1'b1;
        if (q > q_max) begin
            r.q = q_max;
        end else if (q < q_min) begin
            r.q = q_min;
        end else begin
            r.q   = q;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with fall-through head; pushes when full and pops when
// empty are ignored. DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head is read combinationally so the consumer sees it in the same cycle.
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/result_writer.sv
// Drain end of the matmul datapath: requantizes accumulator results, buffers them
// and writes them row-major into C memory through a granted write port.
module result_writer
    import matmul_pkg::*;
#(
    parameter int unsigned M          = C_M,
    parameter int unsigned N          = C_N,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic signed [ACC_WIDTH-1:0] in_data,
    output logic                        in_ready,
    output logic                        mem_we,
    output logic [$clog2(M*N)-1:0]      mem_addr,
    output logic [OUT_WIDTH-1:0]        mem_din,
    input  logic                        mem_gnt,
    output logic                        busy,
    output logic                        done,
    output logic                        drop_err,
    output logic [15:0]                 sat_count
);

    localparam int unsigned TOTAL  = M * N;
    localparam int unsigned ADDR_W = $clog2(M * N);
    localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
    localparam int unsigned QW     = OUT_WIDTH + 1;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       accepted_q, accepted_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   we_q, we_d;
    logic [OUT_WIDTH-1:0]   din_q, din_d;
    logic                   done_q, done_d;
    logic                   drop_q, drop_d;
    logic [15:0]            sat_q, sat_d;

    logic                   push, pop, grant, last_grant;
    logic                   fifo_full, fifo_empty;
    logic [OUT_WIDTH-1:0]   fifo_dout;
    logic [OUT_WIDTH-1:0]   push_data;
    logic                   push_sat;

    assign {push_data, push_sat} = QW'(quantize(64'(in_data), SHIFT, OUT_WIDTH));

    assign in_ready   = (state_q == RUN) && !fifo_full && (accepted_q < CNT_W'(TOTAL));
    assign push       = in_valid && in_ready;
    assign grant      = we_q && mem_gnt;
    assign last_grant = grant && (addr_q == ADDR_W'(TOTAL - 1));
    // Output register refills whenever it is empty or its write is leaving this cycle.
    assign pop        = (state_q == RUN) && !fifo_empty && (!we_q || grant);

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        accepted_d = accepted_q;
        addr_d     = addr_q;
        we_d       = we_q;
        din_d      = din_q;
        done_d     = 1'b0;
        drop_d     = drop_q;
        sat_d      = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    accepted_d = '0;
                    addr_d     = '0;
                    sat_d      = '0;
                    drop_d     = 1'b0;
                end
            end
            RUN: begin
                if (push) begin
                    accepted_d = accepted_q + CNT_W'(1);
                    if (push_sat && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
                end
                if (in_valid && !in_ready) drop_d = 1'b1;
                if (grant) begin
                    we_d = 1'b0;
                    if (!last_grant) addr_d = addr_q + ADDR_W'(1);
                end
                if (pop) begin
                    we_d  = 1'b1;
                    din_d = fifo_dout;
                end
                if (last_grant) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            accepted_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            din_q      <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            sat_q      <= '0;
        end else begin
            state_q    <= state_d;
            accepted_q <= accepted_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            din_q      <= din_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            sat_q      <= sat_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign drop_err  = drop_q;
    assign sat_count = sat_q;

endmodule

// File: tb/tb_result_writer.sv
// Randomized self-checking bench for result_writer with a 2x2 C matrix.
module tb_result_writer;

    localparam int M = 2, N = 2, ACC_W = 32, OUT_W = 8, SH = 4, DEP = 4, DEP2 = 2;
    localparam int TOTAL = M * N;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, mem_gnt = 1'b0;
    logic signed [ACC_W-1:0] in_data = '0;
    logic in_ready, mem_we, busy, done, drop_err;
    logic [1:0] mem_addr;
    logic [OUT_W-1:0] mem_din;
    logic [15:0] sat_count;

    logic start2 = 1'b0, in_valid2 = 1'b0, mem_gnt2 = 1'b0;
    logic signed [ACC_W-1:0] in_data2 = '0;
    logic in_ready2, mem_we2, busy2, done2, drop_err2;
    logic [1:0] mem_addr2;
    logic [OUT_W-1:0] mem_din2;
    logic [15:0] sat_count2;

    result_writer #(.M(M), .N(N), .ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W), .SHIFT(SH), .FIFO_DEPTH(DEP)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_gnt(mem_gnt), .busy(busy), .done(done), .drop_err(drop_err), .sat_count(sat_count));

    result_writer #(.M(M), .N(N), .ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W), .SHIFT(SH), .FIFO_DEPTH(DEP2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2),
        .mem_gnt(mem_gnt2), .busy(busy2), .done(done2), .drop_err(drop_err2), .sat_count(sat_count2));

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected stream in accept order, observed writes in grant order.
    logic [OUT_W-1:0]     exp_q[$];
    int                   exp_sat;
    int                   acc_cyc[$];
    logic signed [ACC_W-1:0] stim_q[$];
    logic [1:0]           mon_addr[$];
    logic [OUT_W-1:0]     mon_data[$];
    int                   mon_cyc[$];
    int                   done_cnt = 0, done_cyc = 0;
    logic                 done_busy = 1'b0;
    logic                 hold_pend = 1'b0;
    logic [1:0]           hold_addr;
    logic [OUT_W-1:0]     hold_din;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                n_checks++;
                if (!(mem_we === 1'b1 && mem_addr === hold_addr && mem_din === hold_din))
                    $display("FAIL hold_stable: got we=%b addr=%0d din=%0d need we=1 addr=%0d din=%0d",
                             mem_we, mem_addr, mem_din, hold_addr, hold_din);
                else n_pass++;
            end
            hold_pend = mem_we && !mem_gnt;
            hold_addr = mem_addr;
            hold_din  = mem_din;
            if (mem_we && mem_gnt) begin
                mon_addr.push_back(mem_addr);
                mon_data.push_back(mem_din);
                mon_cyc.push_back(cyc);
                $display("write addr=%0d data=%0d cyc=%0d", mem_addr, $signed(mem_din), cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    // Reference: floor((x + 2^(SH-1)) / 2^SH) with integer division, then clamp.
    function automatic void model_q(input longint x, output logic [OUT_W-1:0] q, output int sat);
        longint d, t, f;
        d = longint'(1) << SH;
        t = x + d / 2;
        if (t >= 0) f = t / d;
        else        f = -((-t + d - 1) / d);
        sat = 0;
        if (f > 127)       begin f = 127;  sat = 1; end
        else if (f < -128) begin f = -128; sat = 1; end
        q = f[OUT_W-1:0];
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic clear_sb;
        exp_q.delete(); acc_cyc.delete(); mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
        exp_sat = 0;
    endtask

    task automatic pulse_start;
        start = 1'b1; tick; start = 1'b0;
    endtask

    // Presents stim_q in order with random valid gaps and random grants.
    task automatic feed(input int gnt_pct, input int valid_pct);
        int idx = 0, guard = 0, s;
        logic [OUT_W-1:0] q;
        while (idx < stim_q.size() && guard < 500) begin
            in_valid = ($urandom_range(99) < valid_pct);
            in_data  = stim_q[idx];
            mem_gnt  = ($urandom_range(99) < gnt_pct);
            @(negedge clk);
            if (in_valid && in_ready) begin
                model_q(longint'(stim_q[idx]), q, s);
                exp_q.push_back(q); exp_sat += s; acc_cyc.push_back(cyc); idx++;
                $display("accept data=%0d expect=%0d sat=%0d", stim_q[idx-1], $signed(q), s);
            end
            tick; guard++;
        end
        in_valid = 1'b0;
        if (guard >= 500) begin
            n_checks++;
            $display("FAIL feed_timeout: accepted %0d of %0d", idx, stim_q.size());
        end
    endtask

    task automatic wait_done(input int base);
        int g = 0;
        while (done_cnt == base && g < 300) begin mem_gnt = 1'b1; tick; g++; end
        if (g >= 300) begin
            n_checks++;
            $display("FAIL done_timeout: got no done need done");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tick; tick;
        n_checks++;
        if ({in_ready, mem_we, busy, done, drop_err, mem_addr, mem_din, sat_count} !== '0)
            $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b drop=%b addr=%0d din=%0d sat=%0d need all 0",
                     in_ready, mem_we, busy, done, drop_err, mem_addr, mem_din, sat_count);
        else n_pass++;
        rst_n = 1'b1; tick;
    endtask

    task automatic test_idle_input;
        clear_sb;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = $urandom; mem_gnt = 1'b1;
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL idle_ready: got %b need 0", in_ready); else n_pass++;
            tick;
        end
        in_valid = 1'b0; tick;
        n_checks++;
        if (mon_addr.size() !== 0 || drop_err !== 1'b0)
            $display("FAIL idle_nowrite: got writes=%0d drop=%b need 0/0", mon_addr.size(), drop_err);
        else n_pass++;
    endtask

    task automatic test_quantization;
        int base = done_cnt;
        clear_sb;
        stim_q = '{24, 1000, 4000, -3000};
        pulse_start; feed(100, 100); wait_done(base);
        n_checks++;
        if (mon_addr.size() !== 4) $display("FAIL quant_count: got %0d need 4", mon_addr.size()); else n_pass++;
        for (int i = 0; i < mon_addr.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if ({mon_addr[i], mon_data[i]} !== {2'(i), exp_q[i]})
                $display("FAIL quant_write%0d: got (%0d,%0d) need (%0d,%0d)", i, mon_addr[i], $signed(mon_data[i]), i, $signed(exp_q[i]));
            else n_pass++;
            n_checks++;
            if (mon_cyc[i] !== acc_cyc[i] + 2)
                $display("FAIL quant_latency%0d: got grant cyc %0d need %0d", i, mon_cyc[i], acc_cyc[i] + 2);
            else n_pass++;
        end
        n_checks++;
        if (sat_count !== 16'(exp_sat)) $display("FAIL quant_sat: got %0d need %0d", sat_count, exp_sat); else n_pass++;
        n_checks++;
        if (mon_cyc.size() > 0 && (done_cyc !== mon_cyc[mon_cyc.size()-1] + 1 || done_busy !== 1'b0))
            $display("FAIL quant_done: got done cyc %0d busy %b need cyc %0d busy 0", done_cyc, done_busy, mon_cyc[mon_cyc.size()-1] + 1);
        else n_pass++;
        tick;
        n_checks++;
        if (done_cnt !== base + 1 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL quant_pulse: got pulses %0d done %b busy %b need 1 0 0", done_cnt - base, done, busy);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int base = done_cnt;
        clear_sb;
        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back(int'($urandom_range(8000)) - 4000);
        pulse_start; feed(0, 100);
        for (int i = 0; i < 6; i++) begin
            mem_gnt = 1'b0;
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || mem_we !== 1'b1)
                $display("FAIL bp_stall%0d: got rdy=%b we=%b need rdy=0 we=1", i, in_ready, mem_we);
            else n_pass++;
            tick;
        end
        n_checks++;
        if (mon_addr.size() !== 0) $display("FAIL bp_nowrite: got %0d writes need 0", mon_addr.size()); else n_pass++;
        wait_done(base);
        n_checks++;
        if (mon_addr.size() !== 4 || drop_err !== 1'b0)
            $display("FAIL bp_final: got writes=%0d drop=%b need 4/0", mon_addr.size(), drop_err);
        else n_pass++;
        for (int i = 0; i < mon_addr.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if ({mon_addr[i], mon_data[i]} !== {2'(i), exp_q[i]})
                $display("FAIL bp_write%0d: got (%0d,%0d) need (%0d,%0d)", i, mon_addr[i], mon_data[i], i, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        int base;
        for (int r = 0; r < 5; r++) begin
            base = done_cnt;
            clear_sb;
            if (r == 0)      stim_q = '{2039, 2040, -2056, -2057};
            else if (r == 1) stim_q = '{32'sh7FFFFFFF, 32'sh80000000, 0, -8};
            else begin
                stim_q.delete();
                for (int i = 0; i < 4; i++)
                    stim_q.push_back(($urandom_range(3) == 0) ? $urandom : int'($urandom_range(6000)) - 3000);
            end
            pulse_start; feed(60, 70); wait_done(base);
            n_checks++;
            if (mon_addr.size() !== 4 || sat_count !== 16'(exp_sat) || drop_err !== 1'b0 || done_cnt !== base + 1)
                $display("FAIL rand%0d_summary: got writes=%0d sat=%0d drop=%b done=%0d need 4/%0d/0/1",
                         r, mon_addr.size(), sat_count, drop_err, done_cnt - base, exp_sat);
            else n_pass++;
            for (int i = 0; i < mon_addr.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if ({mon_addr[i], mon_data[i]} !== {2'(i), exp_q[i]})
                    $display("FAIL rand%0d_write%0d: got (%0d,%0d) need (%0d,%0d)", r, i, mon_addr[i], $signed(mon_data[i]), i, $signed(exp_q[i]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_extra_inputs;
        int base = done_cnt, idx = 0, guard = 0, s;
        logic [OUT_W-1:0] q;
        clear_sb;
        stim_q = '{4000, -100, 300, 77};
        pulse_start;
        while (idx < 4 && guard < 50) begin
            in_valid = 1'b1; in_data = stim_q[idx]; mem_gnt = 1'b1;
            start = (idx == 2);
            @(negedge clk);
            if (in_ready) begin
                model_q(longint'(stim_q[idx]), q, s);
                exp_q.push_back(q); exp_sat += s; idx++;
            end
            tick; guard++;
        end
        start = 1'b0;
        in_data = 555; tick;
        in_valid = 1'b0;
        wait_done(base);
        repeat (4) tick;
        n_checks++;
        if (drop_err !== 1'b1) $display("FAIL extra_drop: got %b need 1", drop_err); else n_pass++;
        n_checks++;
        if (mon_addr.size() !== 4 || sat_count !== 16'(exp_sat) || busy !== 1'b0)
            $display("FAIL extra_summary: got writes=%0d sat=%0d busy=%b need 4/%0d/0", mon_addr.size(), sat_count, busy, exp_sat);
        else n_pass++;
        for (int i = 0; i < mon_addr.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if ({mon_addr[i], mon_data[i]} !== {2'(i), exp_q[i]})
                $display("FAIL extra_write%0d: got (%0d,%0d) need (%0d,%0d)", i, mon_addr[i], mon_data[i], i, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow;
        logic [OUT_W-1:0] exp2[$];
        logic [1:0]       got_a[$];
        logic [OUT_W-1:0] got_d[$];
        logic [OUT_W-1:0] q;
        int s, accepted = 0, cap;
        cap = (DEP2 + 1 < TOTAL) ? DEP2 + 1 : TOTAL;
        start2 = 1'b1; tick; start2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid2 = 1'b1; in_data2 = int'($urandom_range(4000)) - 2000; mem_gnt2 = 1'b0;
            @(negedge clk);
            if (in_ready2) begin
                model_q(longint'(in_data2), q, s);
                exp2.push_back(q); accepted++;
            end
            tick;
        end
        in_valid2 = 1'b0;
        n_checks++;
        if (accepted !== cap || drop_err2 !== 1'b1)
            $display("FAIL ovf_accept: got accepted=%0d drop=%b need %0d/1", accepted, drop_err2, cap);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            mem_gnt2 = 1'b1;
            @(negedge clk);
            if (mem_we2 && mem_gnt2) begin got_a.push_back(mem_addr2); got_d.push_back(mem_din2); end
            tick;
        end
        n_checks++;
        if (got_a.size() !== cap) $display("FAIL ovf_writes: got %0d need %0d", got_a.size(), cap); else n_pass++;
        for (int i = 0; i < got_a.size() && i < exp2.size(); i++) begin
            n_checks++;
            if ({got_a[i], got_d[i]} !== {2'(i), exp2[i]})
                $display("FAIL ovf_write%0d: got (%0d,%0d) need (%0d,%0d)", i, got_a[i], got_d[i], i, exp2[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run;
        int base, idx = 0, guard = 0, s;
        logic [OUT_W-1:0] q;
        clear_sb;
        stim_q = '{5000, -40, 90, 1234};
        pulse_start;
        while (mon_addr.size() < 2 && guard < 50) begin
            in_valid = (idx < 4); in_data = stim_q[idx % 4]; mem_gnt = 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            tick; guard++;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mem_we, busy, done, drop_err, mem_addr, mem_din, sat_count, busy2} !== '0)
            $display("FAIL midreset_outputs: got rdy=%b we=%b busy=%b done=%b drop=%b addr=%0d din=%0d sat=%0d need all 0",
                     in_ready, mem_we, busy, done, drop_err, mem_addr, mem_din, sat_count);
        else n_pass++;
        tick; tick; rst_n = 1'b1; tick;
        base = done_cnt;
        clear_sb;
        stim_q = '{-5000, 16, 2100, -7};
        pulse_start; feed(80, 80); wait_done(base);
        n_checks++;
        if (mon_addr.size() !== 4 || sat_count !== 16'(exp_sat))
            $display("FAIL midreset_rerun: got writes=%0d sat=%0d need 4/%0d", mon_addr.size(), sat_count, exp_sat);
        else n_pass++;
        for (int i = 0; i < mon_addr.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if ({mon_addr[i], mon_data[i]} !== {2'(i), exp_q[i]})
                $display("FAIL midreset_write%0d: got (%0d,%0d) need (%0d,%0d)", i, mon_addr[i], mon_data[i], i, exp_q[i]);
            else n_pass++;
        end
        q = '0; s = 0;
    endtask

    initial begin
        test_reset;
        test_idle_input;
        test_quantization;
        test_backpressure;
        test_random;
        test_extra_inputs;
        test_overflow;
        test_reset_mid_run;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Drain end of the matmul datapath. Accepts accumulator results streamed from the PE array.
- Requantizes each result from ACC_WIDTH to OUT_WIDTH by rounding right-shift with saturation.
- Buffers results in a small FIFO and writes them row-major into the C result memory through the write port of a mem_dp instance.
- Write port uses a grant handshake. Signals done once all M*N results are committed.

Parameters:
- M, 64, rows of C
- N, 64, columns of C
- ACC_WIDTH, 32, signed width of incoming accumulator results
- OUT_WIDTH, 8, signed width of stored C elements
- SHIFT, 4, arithmetic right-shift applied before saturation (0..ACC_WIDTH-1)
- FIFO_DEPTH, 4, result buffer entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a new M*N drain
- in_valid  in  1  result valid from PE array
- in_data  in  ACC_WIDTH  signed accumulator result
- in_ready  out  1  writer can accept in_data this cycle
- mem_we  out  1  write request to C memory
- mem_addr  out  $clog2(M*N)  C element address, row-major
- mem_din  out  OUT_WIDTH  requantized element
- mem_gnt  in  1  memory accepted current write this cycle
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse, last write granted
- drop_err  out  1  sticky; a valid result arrived while in_ready=0 during RUN
- sat_count  out  16  number of saturated results this run (saturates at 0xFFFF)

Behaviour:
- Reset (async, rst_n=0): state IDLE. FIFO empty. in_ready, mem_we, busy, done, drop_err = 0. mem_addr, mem_din, sat_count = 0.
- State IDLE: in_ready=0 and in_valid is ignored. start moves the block to RUN. On that edge it clears the accept and write counters, the address, sat_count and drop_err.
- State RUN: busy=1.
  - in_ready = !fifo_full && (accepted < M*N).
  - A push occurs when in_valid && in_ready.
  - in_valid && !in_ready sets drop_err; the sample is lost.
- Requantize at push: t = in_data + (SHIFT>0 ? 1<<(SHIFT-1) : 0) at ACC_WIDTH+1 bits, then q = t >>> SHIFT.
  - q is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - A clamp increments sat_count. The FIFO stores OUT_WIDTH bits.
- Write stage: a single output register drives mem_we, mem_addr and mem_din.
  - It loads the FIFO head when it is empty or when the current write is granted (mem_we && mem_gnt).
  - mem_we, mem_addr and mem_din stay stable until granted.
  - On grant, mem_addr increments by 1. Address is not incremented after the last write (index M*N-1).
- Latency: a sample accepted at edge E has mem_we=1 from edge E+1, given an empty FIFO and an idle write stage.
- Throughput: with mem_gnt tied high, one result per cycle is sustained; FIFO occupancy never exceeds 1.
- Full FIFO: in_ready=0. A pop in the same cycle does not allow a same-cycle push (no bypass).
- Completion: on the grant of write M*N-1, done pulses for 1 cycle in the following cycle. busy falls with done and the state returns to IDLE. drop_err and sat_count are held until the next start.
- start while busy: ignored.
- in_valid after M*N accepted: in_ready=0, drop_err set.
- Reset mid-run: everything is abandoned immediately. No partial write is guaranteed and the memory contents are unspecified.

Decomposition:
- Shared package matmul_pkg:
  - state enum {IDLE, RUN}
  - function quantize(acc, shift) -> {q, sat_flag}
  - localparam for C address width $clog2(M*N)
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, full, empty, dout; async active-low reset). It is reusable for the A/B feed side.

Test Plan:
- Setup for all tests: M=N=2, SHIFT=4, OUT_WIDTH=8, mem_gnt=1.
- Quantization: start, then feed 24, 1000, 4000, -3000. Expect writes (0,2), (1,63), (2,127), (3,-128). Expect sat_count=2, then done one cycle after the 4th grant, and busy=0.
- Backpressure: mem_gnt=0 for 10 cycles while streaming 4 results. Expect:
  - in_ready drops after 4 accepted (3 in FIFO + 1 in the write register), or earlier because the accept count is capped at M*N.
  - mem_we/addr/din held stable.
  - After gnt=1, writes 0..3 complete in order and drop_err=0.
- Overflow: FIFO_DEPTH=2 with mem_gnt=0, and in_valid held high for 6 cycles. Expect drop_err=1 once in_ready=0, and only the accepted samples written.
- Idle/extra inputs:
  - in_valid before start: no write, in_ready=0.
  - A 5th in_valid after 4 accepted: drop_err=1 and no 5th write.
  - A second start while busy: no effect.
- Async reset mid-run: assert rst_n=0 after 2 writes. All outputs go to 0 immediately. A new start rewrites from address 0 with sat_count=0.
